// File: rtl/demux_16ch_seq_if.sv
// Bus bundle for the 16-channel registered demultiplexer: word input side,
// sixteen held channel outputs, update strobes, frame pointer and frame pulse.
interface demux_16ch_seq_if #(
  parameter int width  = 4,
  parameter int swidth = 4
);
  logic              in_valid;
  logic [width-1:0]  i;
  logic [swidth-1:0] sel;
  logic              auto_mode;
  logic              clear;

  logic [width-1:0]  o0, o1, o2, o3, o4, o5, o6, o7;
  logic [width-1:0]  o8, o9, o10, o11, o12, o13, o14, o15;
  logic [15:0]       upd;
  logic [swidth-1:0] ptr;
  logic              frame_done;

  // Valid-only input: a word with in_valid=1 at a rising edge is always taken
  // (there is no ready); its channel register and one-hot upd strobe appear
  // together one cycle later.
  modport master (
    output in_valid, i, sel, auto_mode, clear,
    input  o0, o1, o2, o3, o4, o5, o6, o7,
    input  o8, o9, o10, o11, o12, o13, o14, o15,
    input  upd, ptr, frame_done
  );

  modport slave (
    input  in_valid, i, sel, auto_mode, clear,
    output o0, o1, o2, o3, o4, o5, o6, o7,
    output o8, o9, o10, o11, o12, o13, o14, o15,
    output upd, ptr, frame_done
  );
endinterface

// File: rtl/demux_16ch_seq.sv
// Registered 1-to-16 word distributor: routes each accepted word to a held
// channel register chosen by sel (manual) or by a wrapping frame pointer (auto).
module demux_16ch_seq #(
  parameter int width  = 4,
  parameter int swidth = 4
) (
  input  logic              clk,
  input  logic              rst,
  demux_16ch_seq_if.slave   bus
);

  logic [width-1:0]  r_ch [16];
  logic [15:0]       r_upd;
  logic [swidth-1:0] r_ptr;
  logic              r_frame_done;

  logic [swidth-1:0] w_ch;
  logic [15:0]       w_onehot;
  logic              w_last_slot;

  assign w_ch        = bus.auto_mode ? r_ptr : bus.sel;
  assign w_onehot    = 16'(1) << w_ch;
  assign w_last_slot = (r_ptr == {swidth{1'b1}});

  // Reset and clear share one path; clear drops the word offered alongside it.
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      for (int k = 0; k < 16; k++) r_ch[k] <= '0;
      r_upd        <= '0;
      r_ptr        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_upd        <= '0;
      r_frame_done <= 1'b0;
      if (bus.in_valid) begin
        r_ch[w_ch] <= bus.i;
        r_upd      <= w_onehot;
        // Pointer only advances in auto mode, so manual writes to channel 15
        // never signal a frame boundary.
        if (bus.auto_mode) begin
          r_ptr        <= r_ptr + swidth'(1);
          r_frame_done <= w_last_slot;
        end
      end
    end
  end

  assign bus.o0         = r_ch[0];
  assign bus.o1         = r_ch[1];
  assign bus.o2         = r_ch[2];
  assign bus.o3         = r_ch[3];
  assign bus.o4         = r_ch[4];
  assign bus.o5         = r_ch[5];
  assign bus.o6         = r_ch[6];
  assign bus.o7         = r_ch[7];
  assign bus.o8         = r_ch[8];
  assign bus.o9         = r_ch[9];
  assign bus.o10        = r_ch[10];
  assign bus.o11        = r_ch[11];
  assign bus.o12        = r_ch[12];
  assign bus.o13        = r_ch[13];
  assign bus.o14        = r_ch[14];
  assign bus.o15        = r_ch[15];
  assign bus.upd        = r_upd;
  assign bus.ptr        = r_ptr;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_demux_16ch_seq.sv
// Bench for demux_16ch_seq: manual-routing vector table plus hand-written
// auto-frame, gap/mode-switch, clear and mid-frame reset sequences.
module tb_demux_16ch_seq;

  localparam int W  = 4;
  localparam int SW = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_16ch_seq_if #(.width(W), .swidth(SW)) bus ();

  demux_16ch_seq #(.width(W), .swidth(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [W-1:0] dut_o [0:15];
  assign dut_o = '{bus.o0, bus.o1, bus.o2, bus.o3, bus.o4, bus.o5, bus.o6, bus.o7,
                   bus.o8, bus.o9, bus.o10, bus.o11, bus.o12, bus.o13, bus.o14, bus.o15};

  // ---------------- model + scoreboard ----------------
  // Queue entry: {frame_done, channel, data}
  logic [W+SW:0] exp_q [$];
  logic [W-1:0]  m_o [16];
  logic [SW-1:0] m_ptr;
  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [SW-1:0] sel;
    logic [W-1:0]  data;
    logic [15:0]   exp_upd;
    logic [SW-1:0] exp_ptr;
  } vec_t;
  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 16; k++) m_o[k] = '0;
    m_ptr = '0;
    exp_q.delete();
  endtask

  task automatic cycle();
    logic [W+SW:0] e;
    @(posedge clk);
    #1;
    chk("ptr", 32'(bus.ptr), 32'(m_ptr));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("upd", 32'(bus.upd), 32'(16'(1) << e[W+SW-1:W]));
      chk("chan_data", 32'(dut_o[e[W+SW-1:W]]), 32'(e[W-1:0]));
      chk("frame_done", 32'(bus.frame_done), 32'(e[W+SW]));
    end else begin
      chk("upd_idle", 32'(bus.upd), 32'h0);
      chk("frame_done_idle", 32'(bus.frame_done), 32'h0);
    end
  endtask

  task automatic check_all(input string name);
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (dut_o[k] !== m_o[k]) begin
        n_errors++;
        $display("FAIL %s o%0d: got %0h expected %0h", name, k, dut_o[k], m_o[k]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input logic auto_m, input logic [SW-1:0] s, input logic [W-1:0] d);
    logic [SW-1:0] ch;
    logic fd;
    bus.in_valid  = 1'b1;
    bus.auto_mode = auto_m;
    bus.sel       = s;
    bus.i         = d;
    bus.clear     = 1'b0;
    ch = auto_m ? m_ptr : s;
    fd = auto_m && (m_ptr == 4'hF);
    m_o[ch] = d;
    if (auto_m) m_ptr = m_ptr + 1'b1;
    exp_q.push_back({fd, ch, d});
    cycle();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
    bus.sel      = 4'($urandom_range(0, 15));
    bus.i        = 4'($urandom_range(0, 15));
    cycle();
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    model_clear();
    cycle();
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [W-1:0] d;
    for (int k = 0; k < 16; k++) begin
      vecs[k].sel     = 4'(k);
      vecs[k].data    = 4'(k) ^ 4'hA;
      vecs[k].exp_upd = 16'(1) << k;
      vecs[k].exp_ptr = 4'h0;
    end

    bus.in_valid  = 1'b1;
    bus.i         = 4'hF;
    bus.sel       = 4'h3;
    bus.auto_mode = 1'b0;
    bus.clear     = 1'b0;
    model_clear();

    // Reset held 2 cycles with a valid word present
    rst = 1'b1;
    cycle();
    cycle();
    check_all("reset");
    rst = 1'b0;

    // Manual routing table
    for (int k = 0; k < 16; k++) begin
      send(1'b0, vecs[k].sel, vecs[k].data);
      chk("tbl_upd", 32'(bus.upd), 32'(vecs[k].exp_upd));
      chk("tbl_ptr", 32'(bus.ptr), 32'(vecs[k].exp_ptr));
    end
    check_all("manual");

    // Auto frame of 16 words; sel randomized to show it is ignored
    for (int k = 0; k < 16; k++) send(1'b1, 4'($urandom_range(0, 15)), 4'(k));
    check_all("auto_frame");
    chk("ptr_wrap", 32'(bus.ptr), 32'h0);

    // Gaps and mode switch
    for (int k = 0; k < 5; k++) begin
      d = 4'($urandom_range(0, 15));
      send(1'b1, 4'h0, d);
    end
    for (int k = 0; k < 3; k++) idle();
    chk("ptr_after_gap", 32'(bus.ptr), 32'h5);
    send(1'b0, 4'hC, 4'h7);
    chk("o12_manual", 32'(bus.o12), 32'h7);
    chk("ptr_hold_manual", 32'(bus.ptr), 32'h5);
    send(1'b1, 4'h0, 4'h9);
    chk("o5_resume", 32'(bus.o5), 32'h9);
    chk("ptr_resume", 32'(bus.ptr), 32'h6);
    check_all("mode_switch");

    // Clear with a valid word at ptr = 9
    for (int k = 0; k < 3; k++) send(1'b1, 4'h0, 4'(k + 1));
    chk("ptr_before_clear", 32'(bus.ptr), 32'h9);
    bus.in_valid  = 1'b1;
    bus.auto_mode = 1'b1;
    bus.i         = 4'hC;
    bus.clear     = 1'b1;
    model_clear();
    cycle();
    bus.clear = 1'b0;
    check_all("clear");
    idle();
    check_all("clear_hold");

    // Mid-frame reset then a full frame of 4'h3
    for (int k = 0; k < 10; k++) send(1'b1, 4'h0, 4'(15 - k));
    pulse_rst();
    check_all("mid_rst");
    for (int k = 0; k < 16; k++) send(1'b1, 4'h0, 4'h3);
    check_all("post_rst_frame");
    idle();

    bus.in_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demux_16ch_seq.md
Name: demux_16ch_seq

Overview:
- Registered 1-to-16 demultiplexer and word distributor: the receive-side counterpart of the 16-to-1 mux family.
- Routes each accepted width-bit input word into one of 16 held output registers.
- The target channel comes from an explicit select (manual mode) or an internal auto-incrementing channel pointer (auto mode).
- Auto mode lets the block rebuild a 16-word frame from a serial word stream; it sits downstream of a mux-based serializer.

Parameters:
- width, 4, bit width of the data word and of each output channel.
- swidth, 4, select/pointer width; fixed at 4 (16 channels); other values are unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input word i is valid this cycle and is accepted (no backpressure)
- i  input  width  data word
- sel  input  swidth  target channel in manual mode; ignored in auto mode
- auto_mode  input  1  1 = target channel is the internal pointer ptr; 0 = target channel is sel
- clear  input  1  synchronous clear of data, pointer and strobes
- o0..o15  output  width each  held channel registers
- upd  output  16  one-hot per-channel update strobe, one cycle wide
- ptr  output  swidth  current auto-mode channel pointer
- frame_done  output  1  one-cycle pulse when auto mode writes channel 15

Behaviour:
- Reset (rst=1 at a clk edge):
  - o0..o15 = 0, upd = 16'h0000, ptr = 0, frame_done = 0.
  - rst has priority over clear and in_valid.
  - Reset mid-frame discards the partial frame; ptr returns to 0.
- Clear (clear=1, rst=0):
  - Same effect as reset on all outputs.
  - Has priority over in_valid; the word presented in that cycle is dropped.
- Target channel: ch = auto_mode ? ptr : sel, sampled in the accepting cycle.
- Accept (in_valid=1, rst=0, clear=0):
  - At the next edge, o[ch] <= i and upd <= (1 << ch).
  - All other channels hold their values.
  - Latency is 1 cycle: data and strobe become visible together.
- No accept: upd = 0 and all channels hold.
  - upd is never multi-hot and never stays high for two cycles unless two consecutive words are accepted.
- Auto-mode pointer:
  - On accept with auto_mode=1, ptr <= ptr+1, wrapping 15 -> 0 modulo 16.
  - frame_done = 1 in the same cycle upd[15] is asserted (the edge that writes channel 15), otherwise 0.
- Manual mode:
  - ptr holds its value and frame_done stays 0, even when sel = 15.
- Changing auto_mode:
  - Takes effect in the cycle it is sampled. ptr is not reset.
  - Returning to auto mode resumes from the held ptr.
- Back-to-back accepts are fully supported, one word per cycle; a full auto frame takes 16 consecutive cycles.
- Writing the same channel repeatedly overwrites it; the last write wins.
- Unknown or X on sel while in_valid=0 has no effect.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1, i=4'hF -> all o = 0, upd = 0, ptr = 0, frame_done = 0.
- Manual routing: with auto_mode=0, drive sel = 0..15 with i = sel ^ 4'hA, one word per cycle -> o[k] = k ^ 4'hA; upd = (1<<k) exactly one cycle after each accept; ptr stays 0; frame_done never asserts.
- Auto frame: with auto_mode=1, send 16 back-to-back words 4'h0..4'hF -> o[k] = k; ptr wraps to 0; frame_done pulses exactly once, coincident with upd = 16'h8000.
- Gaps and mode switch:
  - Send 5 auto words (ptr = 5).
  - Idle 3 cycles -> upd = 0 and ptr = 5.
  - Write one manual word with sel = 12, i = 4'h7 -> o12 = 7, ptr still 5.
  - Resume auto with i = 4'h9 -> o5 = 9, ptr = 6.
- Clear priority: at ptr = 9, assert clear and in_valid together with i = 4'hC -> all o = 0, ptr = 0, upd = 0, and the word is not written.
- Mid-frame reset: after 10 auto words, pulse rst for 1 cycle, then send 16 words 4'h3 -> o0..o15 = 3, and frame_done fires only on the 16th post-reset word.
